// File: rtl/chunked_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
// Shared types and helpers for the chunked add sequencer.
//   add_seq_state_t : sequencer FSM state encoding (IDLE, RUN, DONE)
//   chunk_idx_w()   : width of the chunk index register, at least 1 bit
// ---------------------------------------------------------------------------
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } add_seq_state_t;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int chunk_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunked_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// chunked_add_sequencer_if
// Operand/result handshake bundle of the chunked add sequencer.
//   in_valid/in_ready   : operand set handshake (producer -> sequencer)
//   in_a, in_b, in_cin  : operands and carry-in
//   out_valid/out_ready : result handshake (sequencer -> consumer)
//   out_sum, out_cout   : result and carry-out
//   busy                : sequencer is in RUN or DONE
//   master : producer/consumer side;  slave : sequencer side
//
// full_adder_intf
// Connection to one BITWIDTH-wide adder slice.
//   a, b, cin : slice operands;  sum, cout : slice result
//   master : slice user;  slave : slice implementation
// ---------------------------------------------------------------------------
interface chunked_add_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
endinterface

interface full_adder_intf #(
    parameter int BITWIDTH = 8
);
    logic [BITWIDTH-1:0] a;
    logic [BITWIDTH-1:0] b;
    logic                cin;
    logic [BITWIDTH-1:0] sum;
    logic                cout;

    modport master (output a, b, cin, input sum, cout);
    modport slave  (input a, b, cin, output sum, cout);
endinterface

// File: rtl/chunked_add_sequencer_slice.sv
// ---------------------------------------------------------------------------
// ripple_adder_generic
// Purely combinational BITWIDTH-bit ripple-carry adder slice.
//   fa.a, fa.b, fa.cin : operands and carry-in
//   fa.sum, fa.cout    : sum and carry out of the top bit
// ---------------------------------------------------------------------------
module ripple_adder_generic #(
    parameter int BITWIDTH = 8
) (
    full_adder_intf.slave fa
);

    logic [BITWIDTH-1:0] sum_v;
    logic                carry_v;

    always_comb begin
        sum_v   = '0;
        carry_v = fa.cin;
        for (int unsigned i = 0; i < BITWIDTH; i++) begin
            sum_v[i] = fa.a[i] ^ fa.b[i] ^ carry_v;
            carry_v  = (fa.a[i] & fa.b[i]) | (carry_v & (fa.a[i] ^ fa.b[i]));
        end
    end

    assign fa.sum  = sum_v;
    assign fa.cout = carry_v;

endmodule

// File: rtl/chunked_add_sequencer.sv
// ---------------------------------------------------------------------------
// chunked_add_sequencer
// Wide adder that reuses one CHUNK-bit slice over WIDTH/CHUNK cycles,
// LSB chunk first, with a registered 1-bit carry between chunks.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (aborts any operation)
//   bus  : operand/result handshake (see chunked_add_sequencer_if)
// ---------------------------------------------------------------------------
module chunked_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    chunked_add_sequencer_if.slave  bus
);

    localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int IDXW   = chunk_idx_w(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("chunked_add_sequencer: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("chunked_add_sequencer: WIDTH must be a multiple of CHUNK");
    end

    add_seq_state_t   state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [31:0]      base;

    full_adder_intf #(.BITWIDTH(CHUNK)) slice_if ();

    ripple_adder_generic #(.BITWIDTH(CHUNK)) u_slice (
        .fa (slice_if)
    );

    // Bit offset of the chunk currently being added.
    assign base         = 32'(idx_q) * CHUNK;
    assign slice_if.a   = a_q[base +: CHUNK];
    assign slice_if.b   = b_q[base +: CHUNK];
    assign slice_if.cin = carry_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: CHUNK] = slice_if.sum;
                carry_d              = slice_if.cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_if.cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_chunked_add_sequencer
// Directed and randomised checks of chunked_add_sequencer in a 32/8 and an
// 8/8 configuration against an arithmetic reference (a + b + cin).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_chunked_add_sequencer;

    logic clk;
    logic rst;

    chunked_add_sequencer_if #(.WIDTH(32)) b32 ();
    chunked_add_sequencer_if #(.WIDTH(8))  b8 ();

    chunked_add_sequencer #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    chunked_add_sequencer #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int n_results = 0;
    logic [32:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] add_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference scoreboard for the 32-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (b32.out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut32 unexpected out_valid: got 1, expected 0 (t=%0t)", $time);
                    end else begin
                        check("dut32 result", 64'({b32.out_cout, b32.out_sum}), 64'(exp_q[0]));
                        if (b32.out_ready) begin
                            void'(exp_q.pop_front());
                            n_results++;
                        end
                    end
                end
                if (b32.in_valid && b32.in_ready)
                    exp_q.push_back(add_model(b32.in_a, b32.in_b, b32.in_cin));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic accept32(input logic [31:0] a, input logic [31:0] b, input logic cin);
        int k;
        b32.in_valid = 1'b1;
        b32.in_a     = a;
        b32.in_b     = b;
        b32.in_cin   = cin;
        k = 0;
        @(negedge clk);
        while (!b32.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("accept timeout", 64'(k), 64'(0));
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        b32.in_a     = ~a;
        b32.in_b     = ~b;
        b32.in_cin   = ~cin;
    endtask

    // Counts edges from acceptance until out_valid; returns on a negedge.
    task automatic wait_valid32(output int lat, output int rdy_seen);
        lat      = 0;
        rdy_seen = 0;
        while (!b32.out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (b32.in_ready) rdy_seen++;
        end
    endtask

    task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic [31:0] exp_sum, input logic exp_cout, input string name);
        int lat, rdy_seen;
        accept32(a, b, cin);
        wait_valid32(lat, rdy_seen);
        check({name, " latency"}, 64'(lat), 64'(4));
        check({name, " sum"}, 64'(b32.out_sum), 64'(exp_sum));
        check({name, " cout"}, 64'(b32.out_cout), 64'(exp_cout));
        check({name, " in_ready low while busy"}, 64'(rdy_seen), 64'(0));
        check({name, " busy"}, 64'(b32.busy), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [7:0] exp_sum, input logic exp_cout, input string name);
        int k, lat;
        b8.in_valid = 1'b1;
        b8.in_a     = a;
        b8.in_b     = b;
        b8.in_cin   = cin;
        k = 0;
        @(negedge clk);
        while (!b8.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check({name, " accept timeout"}, 64'(k), 64'(0));
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.in_a     = ~a;
        b8.in_b     = ~b;
        lat = 0;
        while (!b8.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, " latency"}, 64'(lat), 64'(1));
        check({name, " sum"}, 64'(b8.out_sum), 64'(exp_sum));
        check({name, " cout"}, 64'(b8.out_cout), 64'(exp_cout));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, rdy_seen, seen, k, base_results;
        bit done;

        rst          = 1'b1;
        b32.in_valid = 1'b0;
        b32.in_a     = '0;
        b32.in_b     = '0;
        b32.in_cin   = 1'b0;
        b32.out_ready = 1'b1;
        b8.in_valid  = 1'b0;
        b8.in_a      = '0;
        b8.in_b      = '0;
        b8.in_cin    = 1'b0;
        b8.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 64'(b32.in_ready), 64'(1));
        check("reset out_valid", 64'(b32.out_valid), 64'(0));
        check("reset out_sum", 64'(b32.out_sum), 64'(0));
        check("reset out_cout", 64'(b32.out_cout), 64'(0));
        check("reset busy", 64'(b32.busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 64'(b32.busy), 64'(0));
        @(posedge clk);
        #1;

        // Full carry ripple across every chunk
        run_op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "ripple");
        run_op32(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, "cin");

        // Consumer stall with in_valid offered while DONE
        b32.out_ready = 1'b0;
        accept32(32'h0000_FF00, 32'h0000_00FF, 1'b0);
        wait_valid32(lat, rdy_seen);
        check("stall latency", 64'(lat), 64'(4));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            b32.in_valid = 1'b1;
            b32.in_a     = $urandom;
            b32.in_b     = $urandom;
            @(negedge clk);
            check("stall out_valid", 64'(b32.out_valid), 64'(1));
            check("stall sum", 64'(b32.out_sum), 64'(32'h0000_FFFF));
            check("stall cout", 64'(b32.out_cout), 64'(0));
            check("stall in_ready", 64'(b32.in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        @(negedge clk);
        check("post-stall in_ready", 64'(b32.in_ready), 64'(1));
        check("post-stall out_valid", 64'(b32.out_valid), 64'(0));
        @(posedge clk);
        #1;
        b32.out_ready = 1'b1;

        // Reset abort after two RUN cycles
        accept32(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort in_ready", 64'(b32.in_ready), 64'(1));
        check("abort out_valid", 64'(b32.out_valid), 64'(0));
        check("abort sum", 64'(b32.out_sum), 64'(0));
        check("abort cout", 64'(b32.out_cout), 64'(0));
        check("abort busy", 64'(b32.busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b32.out_valid) seen++;
        end
        check("abort no out_valid", 64'(seen), 64'(0));
        @(posedge clk);
        #1;
        run_op32(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, "after abort");

        // Single-chunk configuration
        run_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "n1 overflow");
        run_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "n1 all ones");
        run_op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "n1 nibble carry");

        // Random back-to-back operations with consumer stalls
        base_results = n_results;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    b32.in_valid = 1'b1;
                    b32.in_a     = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
                    b32.in_b     = (i % 11 == 0) ? 32'h0000_0001 : $urandom;
                    b32.in_cin   = 1'($urandom_range(0, 1));
                    k = 0;
                    @(negedge clk);
                    while (!b32.in_ready && k < 200) begin
                        @(negedge clk);
                        k++;
                    end
                    if (k >= 200) check("random accept timeout", 64'(k), 64'(0));
                    @(posedge clk);
                    #1;
                end
                b32.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    b32.out_ready = ($urandom_range(0, 3) != 0);
                end
                b32.out_ready = 1'b1;
            end
        join
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("random drained", 64'(exp_q.size()), 64'(0));
        check("random result count", 64'(n_results - base_results), 64'(1000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
